quad_objective_eval: RTL



---
 rtl/qobj_pkg.sv | 38 +++
 rtl/fixed_param_mult.sv | 30 +++
 rtl/quad_objective_eval.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/qobj_pkg.sv
// Shared types and helpers for the serial quadratic objective evaluator.
// Optional build macro used by the datapath: QOBJ_SATURATE_EN.
package qobj_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DIFF   = 3'd2,
    S_SCALE  = 3'd3,
    S_SQUARE = 3'd4,
    S_ACCUM  = 3'd5,
    S_DONE   = 3'd6
  } qobj_state_e;

  localparam int QOBJ_FRAC    = 8;
  localparam int QOBJ_OUT_W   = 32;
  // Wide enough to hold a full 2*OUT_W product for any OUT_W up to 64.
  localparam int QOBJ_CHECK_W = 128;

  localparam logic [QOBJ_OUT_W-1:0] QOBJ_SAT_MAX = {1'b0, {(QOBJ_OUT_W-1){1'b1}}};
  localparam logic [QOBJ_OUT_W-1:0] QOBJ_SAT_MIN = {1'b1, {(QOBJ_OUT_W-1){1'b0}}};

  // True when the sign-extended value v is representable as a w-bit signed number.
  function automatic logic fits_signed(input logic signed [QOBJ_CHECK_W-1:0] v,
                                       input int w);
    logic signed [QOBJ_CHECK_W-1:0] hi;
    hi = v >>> (w - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  // Clamp value for a w-bit signed result; callers truncate to w bits.
  function automatic logic [QOBJ_CHECK_W-1:0] sat_value(input logic neg, input int w);
    logic [QOBJ_CHECK_W-1:0] lim;
    lim = {QOBJ_CHECK_W{1'b1}} << (w - 1);
    return neg ? lim : ~lim;
  endfunction

endpackage

// File: rtl/fixed_param_mult.sv
// Combinational signed fixed-point multiply: full product, >>> FRAC, range check.
// With QOBJ_SATURATE_EN defined an out-of-range result clamps, otherwise it wraps.
module fixed_param_mult
  import qobj_pkg::*;
#(
  parameter int OUT_W = QOBJ_OUT_W,
  parameter int FRAC  = QOBJ_FRAC
) (
  input  logic signed [OUT_W-1:0] a,
  input  logic signed [OUT_W-1:0] b,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);

  logic signed [2*OUT_W-1:0] prod;
  logic signed [2*OUT_W-1:0] shifted;

  always_comb begin
    prod    = (2*OUT_W)'(a) * (2*OUT_W)'(b);
    // Arithmetic shift floors toward minus infinity.
    shifted = prod >>> FRAC;
    ovf     = !fits_signed(QOBJ_CHECK_W'(shifted), OUT_W);
`ifdef QOBJ_SATURATE_EN
    y = ovf ? OUT_W'(sat_value(shifted[2*OUT_W-1], OUT_W)) : shifted[OUT_W-1:0];
`else
    y = shifted[OUT_W-1:0];
`endif
  end

endmodule

// File: rtl/quad_objective_eval.sv
// Serial evaluator of f(x) = sum_i (s_i*(x_i - c_i))^2 + k with one shared multiplier.
// Build option QOBJ_SATURATE_EN: clamp overflowing arithmetic instead of wrapping.
module quad_objective_eval
  import qobj_pkg::*;
#(
  parameter int N_VARS = 4,
  parameter int IN_W   = 16,
  parameter int FRAC   = QOBJ_FRAC,
  parameter int OUT_W  = QOBJ_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_func,
  input  logic [N_VARS*IN_W-1:0]   x_in,
  input  logic [N_VARS*IN_W-1:0]   centre_in,
  input  logic [N_VARS*IN_W-1:0]   scale_in,
  input  logic [OUT_W-1:0]         offset_in,
  output logic [OUT_W-1:0]         z_out,
  output logic                     func_done,
  output logic                     overflow
);

  localparam int IDX_W = (N_VARS > 1) ? $clog2(N_VARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VARS - 1);

  qobj_state_e state, state_nxt;

  logic [IDX_W-1:0]        idx;
  logic [N_VARS*IN_W-1:0]  x_r, c_r, s_r;
  logic signed [OUT_W-1:0] acc, d_r, p_r, q_r;

  logic signed [IN_W-1:0]  x_sel, c_sel, s_sel;
  logic signed [OUT_W-1:0] x_ext, c_ext, s_ext;
  logic signed [OUT_W-1:0] diff_raw, diff_y, sum_raw, sum_y;
  logic signed [OUT_W-1:0] mult_a, mult_b, mult_y;
  logic                    diff_ovf, sum_ovf, mult_ovf;

  // Operand selection for the current variable, sign-extended to the working width.
  always_comb begin
    x_sel = x_r[int'(idx)*IN_W +: IN_W];
    c_sel = c_r[int'(idx)*IN_W +: IN_W];
    s_sel = s_r[int'(idx)*IN_W +: IN_W];
    x_ext = {{(OUT_W-IN_W){x_sel[IN_W-1]}}, x_sel};
    c_ext = {{(OUT_W-IN_W){c_sel[IN_W-1]}}, c_sel};
    s_ext = {{(OUT_W-IN_W){s_sel[IN_W-1]}}, s_sel};
  end

  // Inline subtractor and accumulator adder; exact-result sign equals the first operand's on overflow.
  always_comb begin
    diff_raw = x_ext - c_ext;
    diff_ovf = (x_ext[OUT_W-1] != c_ext[OUT_W-1]) && (diff_raw[OUT_W-1] != x_ext[OUT_W-1]);
    sum_raw  = acc + q_r;
    sum_ovf  = (acc[OUT_W-1] == q_r[OUT_W-1]) && (sum_raw[OUT_W-1] != acc[OUT_W-1]);
`ifdef QOBJ_SATURATE_EN
    diff_y = diff_ovf ? OUT_W'(sat_value(x_ext[OUT_W-1], OUT_W)) : diff_raw;
    sum_y  = sum_ovf  ? OUT_W'(sat_value(acc[OUT_W-1], OUT_W))   : sum_raw;
`else
    diff_y = diff_raw;
    sum_y  = sum_raw;
`endif
  end

  // The single multiplier serves s*d in SCALE and p*p in SQUARE.
  always_comb begin
    mult_a = (state == S_SQUARE) ? p_r : s_ext;
    mult_b = (state == S_SQUARE) ? p_r : d_r;
  end

  fixed_param_mult #(
    .OUT_W (OUT_W),
    .FRAC  (FRAC)
  ) u_mult (
    .a   (mult_a),
    .b   (mult_b),
    .y   (mult_y),
    .ovf (mult_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_func) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_DIFF;
      S_DIFF:   state_nxt = S_SCALE;
      S_SCALE:  state_nxt = S_SQUARE;
      S_SQUARE: state_nxt = S_ACCUM;
      S_ACCUM:  state_nxt = (idx == LAST_IDX) ? S_DONE : S_DIFF;
      // First DONE cycle publishes the result; leaving needs start_func low afterwards.
      S_DONE:   if (func_done && !start_func) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      x_r       <= '0;
      c_r       <= '0;
      s_r       <= '0;
      acc       <= '0;
      d_r       <= '0;
      p_r       <= '0;
      q_r       <= '0;
      z_out     <= '0;
      func_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          x_r      <= x_in;
          c_r      <= centre_in;
          s_r      <= scale_in;
          acc      <= offset_in;
          idx      <= '0;
          overflow <= 1'b0;
        end
        S_DIFF: begin
          d_r <= diff_y;
          if (diff_ovf) overflow <= 1'b1;
        end
        S_SCALE: begin
          p_r <= mult_y;
          if (mult_ovf) overflow <= 1'b1;
        end
        S_SQUARE: begin
          q_r <= mult_y;
          if (mult_ovf) overflow <= 1'b1;
        end
        S_ACCUM: begin
          acc <= sum_y;
          if (sum_ovf) overflow <= 1'b1;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        S_DONE: begin
          if (!func_done) begin
            func_done <= 1'b1;
            z_out     <= acc;
          end else if (!start_func) begin
            func_done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
